wb_arb_rr_wdog: RTL and testbench
=================================

WB_ARB_RR_WDOG -- requirements
Module: wb_arb_rr_wdog

Interface
REQ-001 SHALL have parameter NM, 8, number of masters.
REQ-002 SHALL have parameter TIMEOUT, 256, cycles without ack before watchdog fires (>=2).
REQ-003 SHALL have port clk_i  input  1  clock; all state on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port req_i  input  NM  per-master CYC request.
REQ-006 SHALL have port ack_i  input  1  termination (ACK|ERR|RTY) from the addressed slave for the granted master.
REQ-007 SHALL have port gnt_o  output  3  index of the granted (or parked) master; drives the bus mux.
REQ-008 SHALL have port gnt_vld_o  output  1  grant active; master gnt_o owns the bus.
REQ-009 SHALL have port err_o  output  1  one-cycle watchdog error pulse to master gnt_o.

Function
REQ-010 SHALL implement states IDLE, BUSY, FLUSH; all outputs registered.
REQ-011 IDLE: gnt_vld_o=0, gnt_o holds last owner (park); if (req_i & ~mask) != 0, next cycle gnt_o=picked index, gnt_vld_o=1, state BUSY.
REQ-012 Pick SHALL be round-robin: first set bit of (req_i & ~mask) searching from last_owner+1 upward, wrapping NM-1 -> 0.
REQ-013 BUSY: hold gnt_o while req_i[gnt_o]=1, regardless of other requests (no preemption).
REQ-014 BUSY with req_i[gnt_o]=0: if other eligible requests, regrant to the pick next cycle (stay BUSY, no dead cycle); else IDLE.
REQ-015 Grant latency: request seen in cycle N -> gnt_vld_o/gnt_o valid in cycle N+1.
REQ-016 Watchdog counter SHALL clear on grant change and on every ack_i; it increments each BUSY cycle without ack_i.
REQ-017 When the counter reaches TIMEOUT-1 with no ack_i that cycle: next cycle err_o=1, gnt_vld_o=0, mask[gnt_o] set, state FLUSH.
REQ-018 ack_i in the terminal-count cycle SHALL win: no err_o, counter cleared.
REQ-019 FLUSH lasts exactly one cycle, then behaves as IDLE (pick with mask applied).
REQ-020 mask[i] SHALL clear in the cycle after req_i[i]=0; a masked master cannot be granted.
REQ-021 Release and ack_i in the same cycle: release handled per REQ-014, counter cleared.
REQ-022 req_i=0 everywhere: state IDLE, gnt_o unchanged indefinitely.

Reset
REQ-023 rst_i SHALL override everything in the same edge, including mid-tenure and during FLUSH.
REQ-024 Reset values: state IDLE, gnt_o=0, gnt_vld_o=0, err_o=0, counter=0, mask=0, last_owner=NM-1 (master 0 first).

Configuration
REQ-025 Macro WB_ARB_WDOG_EN defined: watchdog, mask and FLUSH present per REQ-016..REQ-020.
REQ-026 Macro undefined: no counter, mask or FLUSH; err_o tied 0; tenure unbounded; all other behaviour identical.

Structure
REQ-027 Shared package wb_arb_pkg SHALL hold NM, grant width (3), the state enum and the TIMEOUT default.
REQ-028 Round-robin search SHALL be a combinational sub-module wb_rr_pick (inputs req, mask, last; outputs index, any).

Verification
REQ-029 Reset then req_i=8'h01 -> cycle+1 gnt_o=0, gnt_vld_o=1.
REQ-030 req_i=8'h89 held, owner 0 drops -> gnt_o=3, then 7, then 0 on successive releases; no dead cycles.
REQ-031 Owner 2 holds req with ack_i every 10 cycles for 1000 cycles -> no err_o, gnt_o=2 throughout.
REQ-032 Owner 5 holds req, no ack_i, TIMEOUT=256 -> err_o pulse exactly 256 cycles after grant, gnt_vld_o=0; with req_i=8'h21 next grant is 0; 5 not granted until its req drops.
REQ-033 ack_i asserted exactly at terminal count -> no err_o; counter restarts.
REQ-034 rst_i asserted mid-BUSY (gnt_o=6) -> next cycle gnt_o=0, gnt_vld_o=0; WB_ARB_WDOG_EN undefined build: REQ-032 stimulus -> err_o stays 0, grant held.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared constants and FSM encoding for the round-robin Wishbone arbiter.
package wb_arb_pkg;
   localparam int NM_DEF      = 8;
   localparam int GW          = 3;
   localparam int TIMEOUT_DEF = 256;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FLUSH} state_t;
endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin pick: first eligible request above 'last', wrapping.
module wb_rr_pick
   import wb_arb_pkg::*;
#(
   parameter int NM = NM_DEF
) (
   input  logic [NM-1:0] req_i,
   input  logic [NM-1:0] mask_i,
   input  logic [GW-1:0] last_i,
   output logic [GW-1:0] idx_o,
   output logic          any_o
);
   logic [NM-1:0] elig;
   logic [GW-1:0] j;

   assign elig = req_i & ~mask_i;

   // k runs 1..NM so the previous owner is considered last.
   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      j     = '0;
      for (int k = 1; k <= NM; k++) begin
         j = GW'((int'(last_i) + k) % NM);
         if (!any_o && elig[j]) begin
            idx_o = j;
            any_o = 1'b1;
         end
      end
   end
endmodule

// File: rtl/wb_arb_rr_wdog.sv
// Round-robin Wishbone bus arbiter with optional tenure watchdog.
// Watchdog, mask and FLUSH state are built only when WB_ARB_WDOG_EN is defined.
module wb_arb_rr_wdog
   import wb_arb_pkg::*;
#(
   parameter int NM      = NM_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [NM-1:0] req_i,
   input  logic          ack_i,
   output logic [GW-1:0] gnt_o,
   output logic          gnt_vld_o,
   output logic          err_o
);
   state_t        state_q, state_d;
   logic [GW-1:0] gnt_q, gnt_d, last_q, last_d;
   logic          vld_q, vld_d;
   logic [NM-1:0] mask;
   logic [GW-1:0] pick_idx;
   logic          pick_any;

`ifdef WB_ARB_WDOG_EN
   localparam int CW = $clog2(TIMEOUT);
   logic [CW-1:0] cnt_q, cnt_d;
   logic [NM-1:0] mask_q, mask_d;
   logic          err_q, err_d;

   assign mask  = mask_q;
   assign err_o = err_q;
`else
   logic unused_wdog;
   assign unused_wdog = ack_i ^ (TIMEOUT == 0);
   assign mask  = '0;
   assign err_o = 1'b0;
`endif

   wb_rr_pick #(.NM(NM)) u_pick (
      .req_i  (req_i),
      .mask_i (mask),
      .last_i (last_q),
      .idx_o  (pick_idx),
      .any_o  (pick_any)
   );

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      vld_d   = vld_q;
`ifdef WB_ARB_WDOG_EN
      cnt_d   = '0;
      err_d   = 1'b0;
      mask_d  = mask_q & req_i;
`endif
      case (state_q)
         S_BUSY: begin
            if (req_i[gnt_q]) begin
`ifdef WB_ARB_WDOG_EN
               // An ack on the terminal-count cycle takes priority over the timeout.
               if (!ack_i && cnt_q == CW'(TIMEOUT - 1)) begin
                  err_d          = 1'b1;
                  vld_d          = 1'b0;
                  mask_d[gnt_q]  = 1'b1;
                  state_d        = S_FLUSH;
               end else if (!ack_i) begin
                  cnt_d = cnt_q + 1'b1;
               end
`endif
            end else if (pick_any) begin
               gnt_d  = pick_idx;
               last_d = pick_idx;
            end else begin
               vld_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         S_FLUSH: begin
            vld_d   = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            if (pick_any) begin
               gnt_d   = pick_idx;
               last_d  = pick_idx;
               vld_d   = 1'b1;
               state_d = S_BUSY;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         last_q  <= GW'(NM - 1);
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         vld_q   <= vld_d;
      end
   end

`ifdef WB_ARB_WDOG_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         mask_q <= '0;
         err_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         mask_q <= mask_d;
         err_q  <= err_d;
      end
   end
`endif

   assign gnt_o     = gnt_q;
   assign gnt_vld_o = vld_q;
endmodule

// File: tb/tb_wb_arb_rr_wdog.sv
// Scoreboard bench for wb_arb_rr_wdog; expectations adapt to WB_ARB_WDOG_EN.
module tb_wb_arb_rr_wdog;
   localparam int NM = 8;
   localparam int TO = 256;
`ifdef WB_ARB_WDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic [NM-1:0] req_i = '0;
   logic          ack_i = 1'b0;
   logic [2:0]    gnt_o;
   logic          gnt_vld_o;
   logic          err_o;

   int n_chk = 0;
   int n_err = 0;

   // reference model state
   int            m_st;      // 0 idle, 1 busy, 2 flush
   logic [2:0]    m_gnt, m_last;
   logic          m_vld, m_err;
   int            m_cnt;
   logic [NM-1:0] m_mask;
   logic [4:0]    exp_q[$];

   always #5 clk = ~clk;

   wb_arb_rr_wdog #(.NM(NM), .TIMEOUT(TO)) dut (
      .clk_i     (clk),
      .rst_i     (rst_i),
      .req_i     (req_i),
      .ack_i     (ack_i),
      .gnt_o     (gnt_o),
      .gnt_vld_o (gnt_vld_o),
      .err_o     (err_o)
   );

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [NM-1:0] elig, input logic [2:0] last);
      int i;
      for (int n = 0; n < NM; n++) begin
         i = (int'(last) + 1 + n) % NM;
         if (elig[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_step(input logic [NM-1:0] r, input logic a, input logic rs);
      logic [NM-1:0] elig;
      int p;
      if (rs) begin
         m_st = 0; m_gnt = 0; m_vld = 0; m_err = 0; m_cnt = 0; m_mask = '0; m_last = 3'd7;
         return;
      end
      elig   = WD ? (r & ~m_mask) : r;
      p      = rr_pick(elig, m_last);
      m_mask = m_mask & r;
      m_err  = 0;
      if (m_st == 2) begin
         m_st = 0; m_vld = 0;
      end else if (m_st == 0) begin
         if (p >= 0) begin
            m_gnt = 3'(p); m_last = 3'(p); m_vld = 1; m_st = 1; m_cnt = 0;
         end
      end else if (r[m_gnt]) begin
         if (WD) begin
            if (a) m_cnt = 0;
            else if (m_cnt == TO - 1) begin
               m_err = 1; m_vld = 0; m_mask[m_gnt] = 1'b1; m_st = 2; m_cnt = 0;
            end else m_cnt++;
         end
      end else if (p >= 0) begin
         m_gnt = 3'(p); m_last = 3'(p); m_cnt = 0;
      end else begin
         m_st = 0; m_vld = 0; m_cnt = 0;
      end
   endtask

   // Drive one cycle, predict its result, then compare after the edge.
   task automatic cyc(input logic [NM-1:0] r, input logic a, input logic rs);
      logic [4:0] e;
      req_i = r; ack_i = a; rst_i = rs;
      model_step(r, a, rs);
      exp_q.push_back({m_gnt, m_vld, m_err});
      @(posedge clk); #1;
      e = exp_q.pop_front();
      chk("sb_gnt", int'(gnt_o), int'(e[4:2]));
      chk("sb_vld", int'(gnt_vld_o), int'(e[1]));
      chk("sb_err", int'(err_o), int'(e[0]));
   endtask

   initial begin
      int k_err, errs;
      cyc('0, 0, 1);
      cyc('0, 0, 1);
      chk("rst_gnt", int'(gnt_o), 0);
      chk("rst_vld", int'(gnt_vld_o), 0);
      chk("rst_err", int'(err_o), 0);

      // first grant after reset goes to master 0 in one cycle
      cyc(8'h01, 0, 0);
      chk("first_gnt", int'(gnt_o), 0);
      chk("first_vld", int'(gnt_vld_o), 1);

      // back-to-back regrants on release, no dead cycle
      cyc(8'h89, 0, 0);
      chk("hold0", int'(gnt_o), 0);
      cyc(8'h88, 0, 0);
      chk("rr_3", int'(gnt_o), 3);  chk("rr_3_vld", int'(gnt_vld_o), 1);
      cyc(8'h81, 0, 0);
      chk("rr_7", int'(gnt_o), 7);  chk("rr_7_vld", int'(gnt_vld_o), 1);
      cyc(8'h09, 0, 0);
      chk("rr_0", int'(gnt_o), 0);  chk("rr_0_vld", int'(gnt_vld_o), 1);
      for (int i = 0; i < 5; i++) cyc('0, 0, 0);
      chk("park_gnt", int'(gnt_o), 0);
      chk("park_vld", int'(gnt_vld_o), 0);

      // long tenure kept alive by periodic acks
      errs = 0;
      for (int i = 0; i < 1000; i++) begin
         cyc(8'h04, (i % 10) == 9, 0);
         if (err_o) errs++;
      end
      chk("ack_keep_gnt", int'(gnt_o), 2);
      chk("ack_keep_err", errs, 0);
      cyc('0, 0, 0);

      // no-ack tenure: watchdog fires exactly TO cycles after grant
      cyc(8'h20, 0, 0);
      chk("g5", int'(gnt_o), 5);
      k_err = -1;
      for (int k = 1; k <= 300; k++) begin
         cyc(8'h20, 0, 0);
         if (err_o) begin k_err = k; break; end
      end
      chk("wdog_cycle", k_err, WD ? TO : -1);
      chk("wdog_vld", int'(gnt_vld_o), WD ? 0 : 1);
      cyc(8'h21, 0, 0);
      chk("err_pulse", int'(err_o), 0);
      cyc(8'h21, 0, 0);
      chk("after_wd_gnt", int'(gnt_o), WD ? 0 : 5);
      chk("after_wd_vld", int'(gnt_vld_o), 1);
      cyc(8'h20, 0, 0);
      chk("masked5_vld", int'(gnt_vld_o), WD ? 0 : 1);
      cyc('0, 0, 0);
      cyc(8'h20, 0, 0);
      chk("unmask5_gnt", int'(gnt_o), 5);
      chk("unmask5_vld", int'(gnt_vld_o), 1);

      // ack exactly on terminal count beats the timeout
      errs = 0;
      for (int i = 0; i < TO - 1; i++) begin
         cyc(8'h20, 0, 0);
         if (err_o) errs++;
      end
      cyc(8'h20, 1, 0);
      if (err_o) errs++;
      for (int i = 0; i < 250; i++) begin
         cyc(8'h20, 0, 0);
         if (err_o) errs++;
      end
      chk("ack_tc_err", errs, 0);
      chk("ack_tc_gnt", int'(gnt_o), 5);
      cyc('0, 0, 0);

      // reset in mid-tenure
      cyc(8'h40, 0, 0);
      chk("g6", int'(gnt_o), 6);
      cyc(8'h40, 0, 0);
      cyc(8'h40, 0, 1);
      chk("rst_mid_gnt", int'(gnt_o), 0);
      chk("rst_mid_vld", int'(gnt_vld_o), 0);

      // random traffic against the model
      for (int i = 0; i < 400; i++)
         cyc(NM'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
